seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised, runtime-programmable serial sequence detector (Mealy).
//  Accepts one qualified bit per cycle and flags the cycle in which the last N bits
//  received equal a programmed pattern of length N (1..MAX_LEN).
//  Supports overlapping or non-overlapping detection, a saturating match counter,
//  and both a combinational Mealy flag and a registered, glitch-free flag.
//  Sits between the serial bit front-end and the control/status logic.
// PARAMETERS
//  MAX_LEN  8   maximum pattern length in bits (>=2)
//  LEN_W    4   width of cfg_len; must satisfy 2**LEN_W > MAX_LEN
//  CNT_W    16  width of the match counter
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  d_in         in   1        serial data bit
//  d_valid      in   1        d_in qualifier; the bit is consumed only when this is 1
//  cfg_pattern  in   MAX_LEN  pattern; bit [len-1] is the oldest bit, bit [0] the newest
//  cfg_len      in   LEN_W    pattern length
//  cfg_overlap  in   1        1 = overlapping detection, 0 = non-overlapping
//  cfg_load     in   1        latch the cfg_* inputs and flush the window
//  cnt_clr      in   1        clear the match counter
//  det_mealy    out  1        combinational match flag for the current bit
//  det_reg      out  1        det_mealy registered (1-cycle latency)
//  match_cnt    out  CNT_W    saturating count of matches
//  fill_lvl     out  LEN_W    number of valid bits held in the window (saturates at len)
// BEHAVIOUR
//  Reset (async assert, sync release): shadow pattern = 0, len = 0, overlap = 1,
//   window = 0, fill_lvl = 0, det_reg = 0, match_cnt = 0; det_mealy = 0.
//  cfg_load: on the next edge, latch pattern, len and overlap into shadow registers,
//   then clear the window and fill_lvl. Any d_valid bit in the same cycle is discarded,
//   det_mealy is forced to 0 and match_cnt is cleared.
//  Length rules: shadow len 0 disables the detector (det_mealy is always 0).
//   A cfg_len greater than MAX_LEN is clamped to MAX_LEN at load time.
//  Window: on d_valid, shift {window, d_in}; fill_lvl += 1, saturating at len.
//  det_mealy = d_valid & ~cfg_load & (fill_lvl >= len-1)
//   & ({window,d_in}[len-1:0] == pattern[len-1:0]).
//   The flag is valid in the same cycle as the last pattern bit.
//  Overlap = 1: after a match the window is kept. Example: 1010 on 1010101 gives hits on bits 4 and 6.
//  Overlap = 0: a match sets fill_lvl to 0, so the bits that matched cannot seed the
//   next match. Example: 1010 on 1010101 gives a hit on bit 4 only.
//  When d_valid = 0: the window, fill_lvl and counter hold, and det_mealy = 0.
//  det_reg <= det_mealy every cycle; it is a single-cycle pulse per match.
//  match_cnt: +1 per det_mealy and saturates at 2**CNT_W-1 (no wrap).
//   If cnt_clr and det_mealy occur in the same cycle, the clear wins and the result is 0.
//  Reset mid-stream: all state is dropped immediately; no partial match survives reset.
// STRUCTURE
//  Package seq_det_pkg: MAX_LEN/LEN_W/CNT_W defaults, overlap-mode localparams,
//   function clamp_len(). Legacy 2-bit S0..S3 encodings are not carried over.
//  Sub-module seq_match_window: shift register, fill counter and masked compare.
//   It outputs the raw match.
//  Top level: config shadow registers, mode handling (fill clear), output register, counter.
// TESTING
//  1 Reset, then load 1010/len4/overlap: stream 1010101 -> det_mealy on bits 4 and 6,
//    det_reg one cycle later each time, match_cnt = 2.
//  2 Same stream with overlap = 0 -> a single hit on bit 4, match_cnt = 1, fill_lvl = 0 after the hit.
//  3 Gapped d_valid: send 1,0,(idle x3),1,0 with pattern 1010 -> exactly one hit; idle
//    cycles show det_mealy = 0 and the window is unchanged.
//  4 Boundaries: len = 1 with pattern 1 -> a hit on every valid 1; len = MAX_LEN all-ones -> the first hit
//    comes on valid bit MAX_LEN; len = 0 -> no hits; cfg_len = 15 -> behaves as MAX_LEN.
//  5 cfg_load asserted in the same cycle as a completing bit -> no hit, window flushed,
//    match_cnt = 0; cnt_clr together with a hit -> match_cnt = 0.
//  6 Force match_cnt near saturation with CNT_W = 2 -> holds at 3; assert rst_n low
//    mid-pattern -> outputs are 0 immediately and the next hit needs a full pattern.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared defaults, overlap-mode encodings and the pattern-length clamp
// used by the serial sequence detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CNT_W   = 16;

  localparam logic OVERLAP_ON  = 1'b1;
  localparam logic OVERLAP_OFF = 1'b0;

  // A requested length longer than the window is treated as the full window.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_match_window.sv
// Serial bit window, fill-level tracking and length-masked pattern compare.
// Produces the raw (unregistered) match for the bit currently presented.
module seq_match_window
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               d_in,
  input  logic               d_valid,
  input  logic               flush,
  input  logic               fill_clr,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               raw_match,
  output logic [LEN_W-1:0]   fill_lvl
);

  logic [MAX_LEN-2:0] window_reg;
  logic [LEN_W-1:0]   fill_reg;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic               cmp_ok;
  logic               fill_ok;

  // Candidate window includes the incoming bit so the flag can fire in the same cycle.
  assign cand = {window_reg, d_in};

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign mask[gi] = (LEN_W'(gi) < len);
    end
  endgenerate

  assign cmp_ok  = (((cand ^ pattern) & mask) == '0);
  assign fill_ok = (({1'b0, fill_reg} + (LEN_W+1)'(1)) >= {1'b0, len});

  assign raw_match = d_valid & ~flush & (len != '0) & fill_ok & cmp_ok;

  always_comb begin
    fill_next = fill_reg;
    if (flush) begin
      fill_next = '0;
    end else if (d_valid) begin
      if (fill_clr) begin
        fill_next = '0;
      end else if (fill_reg < len) begin
        fill_next = fill_reg + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_reg <= '0;
      fill_reg   <= '0;
    end else begin
      fill_reg <= fill_next;
      if (flush) begin
        window_reg <= '0;
      end else if (d_valid) begin
        window_reg <= cand[MAX_LEN-2:0];
      end
    end
  end

  assign fill_lvl = fill_reg;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable Mealy sequence detector: config shadow registers,
// overlap handling, registered flag and saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               d_in,
  input  logic               d_valid,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_load,
  input  logic               cnt_clr,
  output logic               det_mealy,
  output logic               det_reg,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   fill_lvl
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic [LEN_W-1:0]   len_clamped;
  logic               raw_match;
  logic               fill_clr;
  logic               det_q_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;

  assign len_clamped = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_reg <= '0;
      len_reg     <= '0;
      overlap_reg <= OVERLAP_ON;
    end else if (cfg_load) begin
      pattern_reg <= cfg_pattern;
      len_reg     <= len_clamped;
      overlap_reg <= cfg_overlap;
    end
  end

  // Non-overlapping mode restarts the fill count so matched bits cannot seed the next hit.
  assign fill_clr = raw_match & (overlap_reg == OVERLAP_OFF);

  seq_match_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_in      (d_in),
    .d_valid   (d_valid),
    .flush     (cfg_load),
    .fill_clr  (fill_clr),
    .pattern   (pattern_reg),
    .len       (len_reg),
    .raw_match (raw_match),
    .fill_lvl  (fill_lvl)
  );

  assign det_mealy = raw_match;

  always_comb begin
    cnt_next = cnt_reg;
    if (cfg_load || cnt_clr) begin
      cnt_next = '0;
    end else if (raw_match && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_q_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      det_q_reg <= raw_match;
      cnt_reg   <= cnt_next;
    end
  end

  assign det_reg   = det_q_reg;
  assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed-vector bench for seq_detector_param with hand-computed expectations;
// uses a 2-bit counter so saturation is reachable in a few hits.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk;
  logic               rst_n;
  logic               d_in;
  logic               d_valid;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cfg_load;
  logic               cnt_clr;
  logic               det_mealy;
  logic               det_reg;
  logic [CNT_W-1:0]   match_cnt;
  logic [LEN_W-1:0]   fill_lvl;

  int n_vec;
  int n_err;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_in        (d_in),
    .d_valid     (d_valid),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_load    (cfg_load),
    .cnt_clr     (cnt_clr),
    .det_mealy   (det_mealy),
    .det_reg     (det_reg),
    .match_cnt   (match_cnt),
    .fill_lvl    (fill_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // All tasks start just after a rising edge and return just after the next one.
  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    d_valid     = 1'b0;
    @(posedge clk); #1;
    chk("load_fill", 32'(fill_lvl), 0);
    chk("load_cnt", 32'(match_cnt), 0);
    $display("load pat=%02h len=%0d ovl=%0b", pat, len, ovl);
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic b, input logic ld, input logic clr,
                      input logic exp_det, input int exp_fill, input int exp_cnt);
    d_in     = b;
    d_valid  = 1'b1;
    cfg_load = ld;
    cnt_clr  = clr;
    #3;
    chk("det_mealy", 32'(det_mealy), 32'(exp_det));
    @(posedge clk); #1;
    chk("det_reg", 32'(det_reg), 32'(exp_det));
    chk("fill_lvl", 32'(fill_lvl), exp_fill);
    chk("match_cnt", 32'(match_cnt), exp_cnt);
    $display("bit d=%0b ld=%0b clr=%0b det=%0b fill=%0d cnt=%0d",
             b, ld, clr, det_reg, fill_lvl, match_cnt);
    d_valid  = 1'b0;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic idle(input int exp_fill, input int exp_cnt);
    d_in    = 1'b1;
    d_valid = 1'b0;
    #3;
    chk("idle_det_mealy", 32'(det_mealy), 0);
    @(posedge clk); #1;
    chk("idle_det_reg", 32'(det_reg), 0);
    chk("idle_fill", 32'(fill_lvl), exp_fill);
    chk("idle_cnt", 32'(match_cnt), exp_cnt);
    $display("idle fill=%0d cnt=%0d", fill_lvl, match_cnt);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    d_in = 1'b0; d_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b1;
    #12;
    chk("rst_det_mealy", 32'(det_mealy), 0);
    chk("rst_det_reg", 32'(det_reg), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    chk("rst_fill", 32'(fill_lvl), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Disabled after reset (len 0): a valid bit never matches
    send(1'b0, 0, 0, 0, 0, 0);

    // Overlapping 1010 on 1010101
    load(8'h0A, 4'd4, 1'b1);
    send(1, 0, 0, 0, 1, 0);
    send(0, 0, 0, 0, 2, 0);
    send(1, 0, 0, 0, 3, 0);
    send(0, 0, 0, 1, 4, 1);
    send(1, 0, 0, 0, 4, 1);
    send(0, 0, 0, 1, 4, 2);
    send(1, 0, 0, 0, 4, 2);

    // Non-overlapping: single hit, fill restarts
    load(8'h0A, 4'd4, 1'b0);
    send(1, 0, 0, 0, 1, 0);
    send(0, 0, 0, 0, 2, 0);
    send(1, 0, 0, 0, 3, 0);
    send(0, 0, 0, 1, 0, 1);
    send(1, 0, 0, 0, 1, 1);
    send(0, 0, 0, 0, 2, 1);
    send(1, 0, 0, 0, 3, 1);

    // Gapped d_valid
    load(8'h0A, 4'd4, 1'b1);
    send(1, 0, 0, 0, 1, 0);
    send(0, 0, 0, 0, 2, 0);
    idle(2, 0);
    idle(2, 0);
    idle(2, 0);
    send(1, 0, 0, 0, 3, 0);
    send(0, 0, 0, 1, 4, 1);

    // len 1, pattern 1: hit on every valid 1, counter saturates at 3
    load(8'h01, 4'd1, 1'b1);
    send(1, 0, 0, 1, 1, 1);
    send(0, 0, 0, 0, 1, 1);
    send(1, 0, 0, 1, 1, 2);
    send(1, 0, 0, 1, 1, 3);
    send(1, 0, 0, 1, 1, 3);
    send(1, 0, 0, 1, 1, 3);

    // len MAX_LEN all ones: first hit on valid bit 8
    load(8'hFF, 4'd8, 1'b1);
    for (int i = 1; i < MAX_LEN; i++) send(1, 0, 0, 0, i, 0);
    send(1, 0, 0, 1, 8, 1);
    send(1, 0, 0, 1, 8, 2);

    // len 0: never hits
    load(8'h00, 4'd0, 1'b1);
    send(0, 0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0, 0);
    send(1, 0, 0, 0, 0, 0);

    // cfg_len 15 clamps to MAX_LEN
    load(8'hFF, 4'd15, 1'b1);
    for (int i = 1; i < MAX_LEN; i++) send(1, 0, 0, 0, i, 0);
    send(1, 0, 0, 1, 8, 1);

    // cfg_load on a completing bit, then cnt_clr together with a hit
    load(8'h0A, 4'd4, 1'b1);
    send(1, 0, 0, 0, 1, 0);
    send(0, 0, 0, 0, 2, 0);
    send(1, 0, 0, 0, 3, 0);
    send(0, 0, 0, 1, 4, 1);
    send(1, 0, 0, 0, 4, 1);
    send(0, 1, 0, 0, 0, 0);
    send(1, 0, 0, 0, 1, 0);
    send(0, 0, 0, 0, 2, 0);
    send(1, 0, 0, 0, 3, 0);
    send(0, 0, 0, 1, 4, 1);
    send(1, 0, 0, 0, 4, 1);
    send(0, 0, 1, 1, 4, 0);

    // Reset mid-stream
    load(8'h0A, 4'd4, 1'b1);
    send(1, 0, 0, 0, 1, 0);
    send(0, 0, 0, 0, 2, 0);
    send(1, 0, 0, 0, 3, 0);
    send(0, 0, 0, 1, 4, 1);
    d_in = 1'b1;
    d_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_det_mealy", 32'(det_mealy), 0);
    chk("midrst_det_reg", 32'(det_reg), 0);
    chk("midrst_cnt", 32'(match_cnt), 0);
    chk("midrst_fill", 32'(fill_lvl), 0);
    $display("reset asserted mid-stream det=%0b cnt=%0d fill=%0d", det_reg, match_cnt, fill_lvl);
    d_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    load(8'h0A, 4'd4, 1'b1);
    send(0, 0, 0, 0, 1, 0);
    send(1, 0, 0, 0, 2, 0);
    send(0, 0, 0, 0, 3, 0);
    send(1, 0, 0, 0, 4, 0);
    send(0, 0, 0, 1, 4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
